hyst_window_gen: RTL and testbench
==================================

Name: hyst_window_gen

Overview:
- Raster-to-window stage directly upstream of the hysteresis thresholding stage in the TOONIFY edge pipeline.
- Accepts one 4-bit non-max-suppressed magnitude pixel per valid cycle, in raster order.
- Emits one 3x3 neighbourhood per image pixel, packed into a 36-bit word, which the hysteresis stage consumes directly.
- Buffers two image lines internally, zero-pads image borders, and drains the last W+1 windows after the final pixel of a frame.

Parameters:
- DSIZE, 4, bits per pixel.
- IMG_W, 640, pixels per line (W); minimum 2.
- IMG_H, 480, lines per frame (H); minimum 2.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  i_pixel valid this cycle; ignored while o_busy=1.
- i_sof  input  1  start of frame; qualified by i_valid; marks pixel (0,0).
- i_pixel  input  DSIZE  input pixel.
- o_window  output  DSIZE*9  3x3 window, row-major, index 0 = top-left at MSBs; element k occupies bits [DSIZE*9-1-k*DSIZE -: DSIZE]; k = (dr+1)*3+(dc+1), dr,dc in {-1,0,1}.
- o_valid  output  1  o_window holds a new window this cycle (single-cycle pulse per window).
- o_busy  output  1  drain in progress; upstream must hold i_valid low.

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; col/row counters 0; line buffers need not be cleared; o_window=0, o_valid=0, o_busy=0.
- Storage: two line buffers of IMG_W x DSIZE (inferred RAM or register array); 3x3 shift window register; column counter 0..W-1; row counter 0..H-1; drain counter 0..W.
- Accepted pixel: i_valid=1 && o_busy=0 && (state RUN, or i_sof=1).
- Pixel stream index n = row*W + col of the accepted pixel.
- Window for centre (r,c) is emitted (o_valid=1) on the cycle after the pixel with index r*W+c+W+1 is accepted.
  - If that index is >= W*H, the window is emitted during DRAIN instead.
  - Lag is exactly W+1 accepted pixels; gaps in i_valid stretch it in time but do not change order.
- Padding: window elements whose (r+dr, c+dc) fall outside [0,H-1] x [0,W-1] are 0. Left and right neighbours never wrap to the adjacent line.
- States and transitions:
  - IDLE: wait for accepted pixel with i_sof=1 -> RUN; counters restart at (0,0) with that pixel at index 0. Pixels with i_sof=0 are dropped.
  - RUN: each accepted pixel advances col, and row on wrap. Accepting pixel index W*H-1 -> DRAIN. i_sof=1 on an accepted pixel mid-frame aborts the frame: pending windows are discarded (no o_valid for them), counters restart, and that pixel becomes index 0.
  - DRAIN: o_busy=1; one synthetic zero step per cycle, W+1 cycles, each producing one window (centres W*H-W-1 .. W*H-1); i_valid and i_sof ignored; then -> IDLE with o_busy=0 on the following cycle.
- Frame totals: exactly W*H o_valid pulses per completed frame; the 0-based emission order matches raster order of centres.
- Back-to-back frames: i_sof may be presented in the first cycle after o_busy falls.
- Async reset mid-operation: immediate return to reset values; no partial windows emitted afterwards.
- Outputs are registered. o_window holds its last value when o_valid=0.

Test Plan:
- Params IMG_W=4, IMG_H=3; feed pixels 0..11 (value = index) contiguously, i_sof on first -> first o_valid one cycle after pixel 5 accepted. Windows: centre0 = {0,0,0,0,0,1,0,4,5}; centre5 = {0,1,2,4,5,6,8,9,10}; centre3 = {0,0,0,2,3,0,6,7,0}.
- Same frame -> 7 windows during RUN. DRAIN then lasts 5 cycles with o_busy=1 and 5 o_valid, the last being centre11 = {6,7,0,10,11,0,0,0,0}. 12 pulses total; o_busy=0 on the next cycle.
- Same frame with random i_valid gaps (about 50% duty) -> identical window sequence and count; no o_valid during gaps except in DRAIN.
- Pixels with i_sof=0 before first i_sof -> no o_valid. Mid-frame i_sof after pixel 7 -> no windows for the aborted frame after the abort; the new frame produces centre0 from the new data.
- i_valid=1 with new data held during DRAIN -> ignored; window contents unchanged vs. idle-input run.
- Assert i_rst_n=0 during DRAIN -> o_valid=0, o_busy=0, o_window=0 immediately; the next frame after release behaves as the first test.

Source files
------------

// File: rtl/hyst_window_gen.sv
// hyst_window_gen
// ---------------
// Raster-to-3x3-window stage feeding the hysteresis thresholding stage.
// One DSIZE-bit magnitude pixel is accepted per valid cycle in raster order.
// For every image pixel a zero-padded 3x3 neighbourhood is emitted, packed
// row-major with the top-left element at the MSBs. Windows lag the input by
// W+1 accepted pixels. After the last pixel of a frame the block drains the
// remaining W+1 windows on its own, feeding zeros into the pipeline.
//
// Handshake: there is no ready signal. A pixel is taken on any rising edge
// where i_valid=1 and o_busy=0, and only if a frame is open or i_sof=1 marks
// a new one. While o_busy=1 (drain), upstream must hold i_valid low; anything
// presented is ignored. o_valid is a one-cycle pulse per window, and o_window
// keeps its last value between pulses.
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_valid, i_sof      pixel qualifier, start-of-frame marker (pixel (0,0))
//   i_pixel             input pixel
//   o_window            packed 3x3 window, element k at [9*DSIZE-1-k*DSIZE -: DSIZE]
//   o_valid             window pulse
//   o_busy              drain in progress
//   o_dbg_state         current FSM state (0 idle, 1 run, 2 drain)

module hyst_window_gen #(
    parameter int DSIZE = 4,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    input  logic               i_sof,
    input  logic [DSIZE-1:0]   i_pixel,
    output logic [DSIZE*9-1:0] o_window,
    output logic               o_valid,
    output logic               o_busy,
    output logic [1:0]         o_dbg_state
);

    localparam int WW = DSIZE * 9;
    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int FW = $clog2(IMG_W + 2);
    localparam int DW = $clog2(IMG_W + 1);

    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
    localparam logic [FW-1:0] FILL_FULL  = FW'(IMG_W + 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(IMG_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    // Position of the next pixel entering the pipeline (keeps counting
    // through the drain so the line buffer address stays in step).
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    // Number of pipeline steps since frame start, saturating at W+1; the
    // pipeline holds a complete window once it is saturated.
    logic [FW-1:0]    fill_q, fill_d;
    // Centre coordinate of the next window to be emitted.
    logic [CW-1:0]    ccol_q, ccol_d;
    logic [RW-1:0]    crow_q, crow_d;
    logic [DW-1:0]    drain_q, drain_d;
    // Unpadded 3x3 shift window, element order as in o_window.
    logic [DSIZE-1:0] win_q [9];
    logic [DSIZE-1:0] win_d [9];
    logic [WW-1:0]    o_window_q, o_window_d;
    logic             o_valid_q, o_valid_d;
    logic             o_busy_q, o_busy_d;

    // Line buffers: lb0 holds the previous line, lb1 the one before it.
    logic [DSIZE-1:0] lb0_mem [IMG_W];
    logic [DSIZE-1:0] lb1_mem [IMG_W];

    logic             accept;
    logic             restart;
    logic             step;
    logic             emit;
    logic [DSIZE-1:0] step_pix;
    logic [CW-1:0]    base_col;
    logic [RW-1:0]    base_row;
    logic [DSIZE-1:0] col_in [3];
    logic [DSIZE-1:0] shift_win [9];
    logic [WW-1:0]    padded;
    logic             pad;

    always_comb begin
        accept   = i_valid && !o_busy_q && ((state_q == ST_RUN) || i_sof);
        restart  = accept && i_sof;
        // A drain cycle is a synthetic step with a zero pixel.
        step     = accept || (state_q == ST_DRAIN);
        step_pix = (state_q == ST_DRAIN) ? '0 : i_pixel;
        base_col = restart ? '0 : col_q;
        base_row = restart ? '0 : row_q;
        emit     = step && !restart && (fill_q == FILL_FULL);

        col_in[0] = lb1_mem[base_col];
        col_in[1] = lb0_mem[base_col];
        col_in[2] = step_pix;

        // Shift the window one column left and append the new column.
        for (int r = 0; r < 3; r++) begin
            shift_win[r*3]     = win_q[r*3+1];
            shift_win[r*3 + 1] = win_q[r*3+2];
            shift_win[r*3 + 2] = col_in[r];
        end

        // Zero the border elements around the emitted centre. This also
        // hides stale line-buffer data and the wrap to the adjacent line.
        padded = '0;
        pad    = 1'b0;
        for (int k = 0; k < 9; k++) begin
            pad = ((k / 3 == 0) && (crow_q == '0))       ||
                  ((k / 3 == 2) && (crow_q == ROW_LAST)) ||
                  ((k % 3 == 0) && (ccol_q == '0))       ||
                  ((k % 3 == 2) && (ccol_q == COL_LAST));
            padded[WW-1-k*DSIZE -: DSIZE] = pad ? '0 : shift_win[k];
        end
    end

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        fill_d     = fill_q;
        ccol_d     = ccol_q;
        crow_d     = crow_q;
        drain_d    = drain_q;
        win_d      = win_q;
        o_window_d = o_window_q;
        o_valid_d  = 1'b0;

        if (step) begin
            win_d = shift_win;
            if (base_col == COL_LAST) begin
                col_d = '0;
                row_d = (base_row == ROW_LAST) ? '0 : base_row + 1'b1;
            end else begin
                col_d = base_col + 1'b1;
                row_d = base_row;
            end
            if (restart) begin
                fill_d = FW'(1);
            end else if (fill_q != FILL_FULL) begin
                fill_d = fill_q + 1'b1;
            end
        end

        // An abort discards the old frame's pending windows: the centre
        // restarts and the pipeline must refill before the next emission.
        if (restart) begin
            ccol_d = '0;
            crow_d = '0;
        end else if (emit) begin
            o_valid_d  = 1'b1;
            o_window_d = padded;
            if (ccol_q == COL_LAST) begin
                ccol_d = '0;
                crow_d = (crow_q == ROW_LAST) ? '0 : crow_q + 1'b1;
            end else begin
                ccol_d = ccol_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (restart) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (accept && (base_col == COL_LAST) && (base_row == ROW_LAST)) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_IDLE;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        o_busy_d = (state_d == ST_DRAIN);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            fill_q     <= '0;
            ccol_q     <= '0;
            crow_q     <= '0;
            drain_q    <= '0;
            for (int k = 0; k < 9; k++) win_q[k] <= '0;
            o_window_q <= '0;
            o_valid_q  <= 1'b0;
            o_busy_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            fill_q     <= fill_d;
            ccol_q     <= ccol_d;
            crow_q     <= crow_d;
            drain_q    <= drain_d;
            win_q      <= win_d;
            o_window_q <= o_window_d;
            o_valid_q  <= o_valid_d;
            o_busy_q   <= o_busy_d;
        end
    end

    // Line buffers carry no reset; their contents before a frame's second
    // line are never visible thanks to the border padding.
    always_ff @(posedge i_clk) begin
        if (step) begin
            lb1_mem[base_col] <= lb0_mem[base_col];
            lb0_mem[base_col] <= step_pix;
        end
    end

    assign o_window    = o_window_q;
    assign o_valid     = o_valid_q;
    assign o_busy      = o_busy_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_hyst_window_gen.sv
module tb_hyst_window_gen;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int DS = 4;
    localparam int WW = DS * 9;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_valid;
    logic          i_sof;
    logic [DS-1:0] i_pixel;
    logic [WW-1:0] o_window;
    logic          o_valid;
    logic          o_busy;
    logic [1:0]    o_dbg_state;

    // ---------------- clock / reset ----------------
    always #5 i_clk = ~i_clk;

    hyst_window_gen #(.DSIZE(DS), .IMG_W(W), .IMG_H(H)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .i_sof       (i_sof),
        .i_pixel     (i_pixel),
        .o_window    (o_window),
        .o_valid     (o_valid),
        .o_busy      (o_busy),
        .o_dbg_state (o_dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int            checks;
    int            failures;
    int            cyc;
    int            m_mode;        // 0 idle, 1 frame open, 2 draining
    int            m_n;           // accepted pixels in the open frame
    int            m_next_c;      // next centre index to emit
    int            m_drain;
    int            m_img [W*H];
    int            acc_lag_cyc;   // cycle pixel index W+1 was accepted
    logic          exp_valid;
    logic          exp_busy;
    logic [WW-1:0] exp_q [$];
    logic [WW-1:0] last_win;
    int            valid_cnt;
    int            busy_cnt;
    int            vb_cnt;
    int            first_valid_cyc;
    logic [WW-1:0] got_q [$];

    function automatic logic [WW-1:0] pk9(input int a0, input int a1, input int a2,
                                          input int a3, input int a4, input int a5,
                                          input int a6, input int a7, input int a8);
        int            a [9];
        logic [WW-1:0] r;
        a = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
        r = '0;
        for (int k = 0; k < 9; k++) r[WW-1-k*DS -: DS] = DS'(a[k]);
        return r;
    endfunction

    // Window of centre index c straight from the stored image, zero outside.
    function automatic logic [WW-1:0] model_win(input int c);
        int            r, col, rr, cc;
        logic [WW-1:0] w;
        w   = '0;
        r   = c / W;
        col = c % W;
        for (int k = 0; k < 9; k++) begin
            rr = r + k / 3 - 1;
            cc = col + k % 3 - 1;
            if (rr >= 0 && rr < H && cc >= 0 && cc < W)
                w[WW-1-k*DS -: DS] = DS'(m_img[rr*W + cc]);
        end
        return w;
    endfunction

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_got(input string name, input int idx, input logic [WW-1:0] exp);
        if (idx < got_q.size()) begin
            check(name, got_q[idx], exp);
        end else begin
            checks++;
            failures++;
            $display("FAIL %s: window %0d never emitted, expected %h", name, idx, exp);
        end
    endtask

    // Model advance for one rising edge.
    task automatic model_step();
        if (!i_rst_n) begin
            m_mode    = 0;
            exp_valid = 1'b0;
            exp_busy  = 1'b0;
            last_win  = '0;
            exp_q.delete();
        end else begin
            exp_valid = 1'b0;
            if (m_mode == 2) begin
                exp_q.push_back(model_win(m_next_c));
                exp_valid = 1'b1;
                m_next_c++;
                m_drain--;
                if (m_drain == 0) m_mode = 0;
            end else if (i_valid && (m_mode == 1 || i_sof)) begin
                if (i_sof) begin
                    m_n      = 0;
                    m_next_c = 0;
                end
                m_mode     = 1;
                m_img[m_n] = int'(i_pixel);
                if (m_n == W + 1) acc_lag_cyc = cyc;
                if (m_n >= W + 1) begin
                    exp_q.push_back(model_win(m_n - W - 1));
                    exp_valid = 1'b1;
                    m_next_c  = m_n - W;
                end
                m_n++;
                if (m_n == W * H) begin
                    m_mode  = 2;
                    m_drain = W + 1;
                end
            end
            exp_busy = (m_mode == 2);
        end
    endtask

    // Compare 1 ns after each rising edge.
    task automatic monitor_cycle();
        logic [WW-1:0] w;
        check1("o_valid", o_valid, exp_valid);
        check1("o_busy", o_busy, exp_busy);
        if (exp_valid) begin
            w = exp_q.pop_front();
            check("o_window", o_window, w);
            last_win = w;
        end else begin
            check("o_window_hold", o_window, last_win);
        end
        if (o_valid) begin
            valid_cnt++;
            got_q.push_back(o_window);
            if (o_busy) vb_cnt++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        if (o_busy) busy_cnt++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [DS-1:0] v, input logic sof);
        @(negedge i_clk);
        i_valid = 1'b1;
        i_sof   = sof;
        i_pixel = v;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge i_clk);
            i_valid = 1'b0;
            i_sof   = 1'b0;
            i_pixel = DS'($urandom_range(0, 15));
        end
    endtask

    // kind 0: value = index; kind 1: value = 15 - index. Sends n_pix pixels.
    task automatic send_frame(input int kind, input bit gaps, input int n_pix);
        for (int i = 0; i < n_pix; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) idle(1);
            drive(DS'((kind == 0) ? i : 15 - i), i == 0);
        end
    endtask

    // ---------------- stimulus + final report ----------------
    initial begin
        int s, b, vb;
        checks          = 0;
        failures        = 0;
        cyc             = 0;
        m_mode          = 0;
        m_n             = 0;
        m_next_c        = 0;
        m_drain         = 0;
        acc_lag_cyc     = -1;
        exp_valid       = 1'b0;
        exp_busy        = 1'b0;
        last_win        = '0;
        valid_cnt       = 0;
        busy_cnt        = 0;
        vb_cnt          = 0;
        first_valid_cyc = -1;
        i_rst_n         = 1'b0;
        i_valid         = 1'b0;
        i_sof           = 1'b0;
        i_pixel         = '0;

        fork
            forever begin
                @(posedge i_clk);
                cyc++;
                model_step();
                #1;
                monitor_cycle();
            end
        join_none

        idle(3);
        check("reset_window", o_window, '0);
        check1("reset_valid", o_valid, 1'b0);
        check1("reset_busy", o_busy, 1'b0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        idle(2);

        // Contiguous frame, value = index.
        s = valid_cnt; b = busy_cnt; vb = vb_cnt; first_valid_cyc = -1;
        send_frame(0, 1'b0, W * H);
        idle(W + 4);
        check_int("t1_pulses", valid_cnt - s, 12);
        check_int("t1_busy_cycles", busy_cnt - b, 5);
        check_int("t1_valid_in_busy", vb_cnt - vb, 5);
        check_int("t1_run_windows", (valid_cnt - s) - (vb_cnt - vb), 7);
        check_int("t1_first_latency", first_valid_cyc, acc_lag_cyc);
        check_got("t1_centre0", s + 0, pk9(0, 0, 0, 0, 0, 1, 0, 4, 5));
        check_got("t1_centre3", s + 3, pk9(0, 0, 0, 2, 3, 0, 6, 7, 0));
        check_got("t1_centre5", s + 5, pk9(0, 1, 2, 4, 5, 6, 8, 9, 10));
        check_got("t1_centre11", s + 11, pk9(6, 7, 0, 10, 11, 0, 0, 0, 0));
        check("model_centre0", model_win(0), pk9(0, 0, 0, 0, 0, 1, 0, 4, 5));
        check("model_centre5", model_win(5), pk9(0, 1, 2, 4, 5, 6, 8, 9, 10));
        check("model_centre11", model_win(11), pk9(6, 7, 0, 10, 11, 0, 0, 0, 0));

        // Same frame with random input gaps.
        s = valid_cnt;
        send_frame(0, 1'b1, W * H);
        idle(W + 4);
        check_int("t2_pulses", valid_cnt - s, 12);
        check_got("t2_centre5", s + 5, pk9(0, 1, 2, 4, 5, 6, 8, 9, 10));
        check_got("t2_centre11", s + 11, pk9(6, 7, 0, 10, 11, 0, 0, 0, 0));

        // Pixels without i_sof while idle, then an aborted frame.
        s = valid_cnt;
        drive(4'd9, 1'b0);
        drive(4'd3, 1'b0);
        drive(4'd7, 1'b0);
        idle(W + 3);
        check_int("t3_no_sof_pulses", valid_cnt - s, 0);
        s = valid_cnt;
        send_frame(0, 1'b0, 8);
        send_frame(1, 1'b0, W * H);
        idle(W + 4);
        check_int("t3_abort_pulses", valid_cnt - s, 15);
        check_got("t3_new_centre0", s + 3, pk9(0, 0, 0, 0, 15, 14, 0, 11, 10));
        check("model_new_centre0", model_win(0), pk9(0, 0, 0, 0, 15, 14, 0, 11, 10));

        // Junk input held high through the drain.
        s = valid_cnt;
        send_frame(0, 1'b0, W * H);
        repeat (W + 1) drive(4'd15, 1'b1);
        idle(W + 2);
        check_int("t4_pulses", valid_cnt - s, 12);
        check_got("t4_centre7", s + 7, pk9(2, 3, 0, 6, 7, 0, 10, 11, 0));
        check_got("t4_centre11", s + 11, pk9(6, 7, 0, 10, 11, 0, 0, 0, 0));

        // Asynchronous reset in the middle of the drain.
        send_frame(0, 1'b0, W * H);
        idle(2);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        check("t5_rst_window", o_window, '0);
        check1("t5_rst_valid", o_valid, 1'b0);
        check1("t5_rst_busy", o_busy, 1'b0);
        idle(2);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        idle(2);
        s = valid_cnt; b = busy_cnt; first_valid_cyc = -1;
        send_frame(0, 1'b0, W * H);
        idle(W + 4);
        check_int("t5_pulses", valid_cnt - s, 12);
        check_int("t5_busy_cycles", busy_cnt - b, 5);
        check_int("t5_first_latency", first_valid_cyc, acc_lag_cyc);
        check_got("t5_centre0", s + 0, pk9(0, 0, 0, 0, 0, 1, 0, 4, 5));
        check_got("t5_centre5", s + 5, pk9(0, 1, 2, 4, 5, 6, 8, 9, 10));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
